// File: rtl/fetch2_pkg.sv
// fetch2_pkg: shared widths and the fetch-queue entry payload for the second
// fetch stage.
//   FQ_DEPTH   - default number of fetch-queue entries
//   INST_W     - instruction width
//   PC_W       - program counter width
//   FQ_ENTRY_W - one queue entry: PC plus two instructions
package fetch2_pkg;

  localparam int unsigned FQ_DEPTH   = 4;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned PAIR_W     = 2 * INST_W;
  localparam int unsigned FQ_ENTRY_W = PC_W + PAIR_W;

  // One fetched pair with its PC; inst0 is at pc, inst1 at pc+4.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst1;
    logic [INST_W-1:0] inst0;
  } fq_entry_t;

  // Build a queue entry from a request PC and the raw imem pair.
  function automatic fq_entry_t make_entry(input logic [PC_W-1:0]   pc,
                                           input logic [PAIR_W-1:0] pair);
    fq_entry_t e;
    e.pc    = pc;
    e.inst1 = pair[PAIR_W-1:INST_W];
    e.inst0 = pair[INST_W-1:0];
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched instruction pairs.
// Ports:
//   clk_i       - clock, rising edge
//   rst_n_i     - synchronous active-low reset (pointers and count only)
//   flush_i     - empties the queue on the next edge; wins over push/pop
//   push_i      - write push_data_i at the tail
//   push_data_i - entry to write
//   pop_i       - drop the head entry (ignored when empty)
//   count_o     - number of valid entries, 0..DEPTH
//   head_o      - head entry, meaningful only while count_o != 0
module fetch_queue
  import fetch2_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fq_entry_t              push_data_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output fq_entry_t              head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [FQ_ENTRY_W-1:0] mem_q [DEPTH];
  logic [FQ_ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_pop;

  // Next-state for storage, pointers and count. Pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i && (count_q != '0);

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end
  end

  // Control state, reset synchronously.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; stale entries are never visible past count.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign count_o = count_q;
  assign head_o  = fq_entry_t'(mem_q[rd_ptr_q]);

endmodule

// File: rtl/fetch2.sv
// fetch2: second fetch stage. Accepts PCs from the PC stage as imem requests,
// pairs each returned 64-bit instruction pair with its PC and buffers it for
// decode behind a valid/ready handshake.
// Ports:
//   clock_i      - clock, rising edge
//   reset_n_i    - synchronous active-low reset
//   pc_i         - current PC (also the imem address)
//   pc_we_o      - PC accepted as a request this cycle; PC stage advances by 8
//   imem_data_i  - imem pair for last cycle's request ([31:0] at PC)
//   flush_i      - discard queued and in-flight fetches
//   dec_valid_o  - head pair valid
//   dec_ready_i  - decode takes the head this cycle
//   dec_pc_o     - PC of head pair
//   dec_inst0_o  - instruction at dec_pc_o
//   dec_inst1_o  - instruction at dec_pc_o+4
module fetch2
  import fetch2_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic              pc_we_o,
  input  logic [PAIR_W-1:0] imem_data_i,
  input  logic              flush_i,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic [PC_W-1:0]   dec_pc_o,
  output logic [INST_W-1:0] dec_inst0_o,
  output logic [INST_W-1:0] dec_inst1_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic              req_valid_q, req_valid_d;
  logic [PC_W-1:0]   req_pc_q, req_pc_d;
  logic [CNT_W-1:0]  count;
  logic              room;
  logic              pop;
  fq_entry_t         push_data;
  fq_entry_t         head;

  // Issue rule and handshake. Issue depends only on registered occupancy
  // (queued + in flight), never on dec_ready_i, so a push can never meet a
  // full queue.
  always_comb begin
    room        = (OCC_W'(count) + OCC_W'(req_valid_q)) < OCC_W'(DEPTH);
    pc_we_o     = reset_n_i & ~flush_i & room;
    req_valid_d = pc_we_o;
    req_pc_d    = pc_i;
    dec_valid_o = reset_n_i & (count != '0);
    pop         = dec_valid_o & dec_ready_i;
    push_data   = make_entry(req_pc_q, imem_data_i);
  end

  // In-flight request register: tracks which PC the imem data belongs to.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i       (clock_i),
    .rst_n_i     (reset_n_i),
    .flush_i     (flush_i),
    .push_i      (req_valid_q),
    .push_data_i (push_data),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  assign dec_pc_o    = head.pc;
  assign dec_inst0_o = head.inst0;
  assign dec_inst1_o = head.inst1;

endmodule

// File: tb/tb_fetch2.sv
// tb_fetch2: self-checking bench for fetch2. A behavioural PC stage and imem
// drive the block; a queue-based reference model tracks what decode should
// see, and a negedge monitor compares every cycle.
module tb_fetch2;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_we_o;
  logic [63:0] imem_data;
  logic        flush;
  logic        dec_valid_o;
  logic        ready;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_inst0_o;
  logic [31:0] dec_inst1_o;

  logic        redirect;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;
  int n_pops = 0;

  // Reference model: expected queue contents {pc, inst1, inst0} plus the
  // single request that is waiting for its imem data.
  logic [95:0] sb[$];
  bit          inf_v = 1'b0;
  logic [95:0] inf_e;

  fetch2 #(.DEPTH(DEPTH)) dut (
    .clock_i     (clk),
    .reset_n_i   (rst_n),
    .pc_i        (pc),
    .pc_we_o     (pc_we_o),
    .imem_data_i (imem_data),
    .flush_i     (flush),
    .dec_valid_o (dec_valid_o),
    .dec_ready_i (ready),
    .dec_pc_o    (dec_pc_o),
    .dec_inst0_o (dec_inst0_o),
    .dec_inst1_o (dec_inst1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC stage and synchronous imem returning {PC+4, PC}.
  always @(posedge clk) begin
    imem_data <= {pc + 32'd4, pc};
    if (redirect)     pc <= redirect_pc;
    else if (pc_we_o) pc <= pc + 32'd8;
  end

  // Monitor: compare DUT against the model mid-cycle, then advance the model
  // across the coming edge.
  always @(negedge clk) begin
    logic exp_we;
    logic exp_valid;
    int   occ;
    occ       = sb.size() + int'(inf_v);
    exp_we    = rst_n && !flush && (occ < int'(DEPTH));
    exp_valid = rst_n && (sb.size() != 0);

    checks++;
    if (pc_we_o !== exp_we) begin
      errors++;
      $display("FAIL pc_we t=%0t got %b want %b", $time, pc_we_o, exp_we);
    end
    checks++;
    if (dec_valid_o !== exp_valid) begin
      errors++;
      $display("FAIL dec_valid t=%0t got %b want %b", $time, dec_valid_o, exp_valid);
    end
    if (exp_valid && dec_valid_o === 1'b1) begin
      checks++;
      if ({dec_pc_o, dec_inst1_o, dec_inst0_o} !== sb[0]) begin
        errors++;
        $display("FAIL head t=%0t got %h want %h", $time,
                 {dec_pc_o, dec_inst1_o, dec_inst0_o}, sb[0]);
      end
    end

    if (!rst_n || flush) begin
      sb.delete();
      inf_v = 1'b0;
    end else begin
      if (exp_valid && ready) begin
        void'(sb.pop_front());
        n_pops++;
      end
      if (inf_v) sb.push_back(inf_e);
      inf_v = exp_we;
      inf_e = {pc, pc + 32'd4, pc};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'd8;
    repeat (cycles) step();
    rst_n    = 1'b1;
    redirect = 1'b0;
  endtask

  initial begin
    int  n_issue;
    bit  found;
    flush = 1'b0;
    ready = 1'b1;

    // Startup with decode always ready.
    do_reset(3);
    repeat (20) step();

    // Full back-pressure from an empty queue: exactly DEPTH requests.
    ready = 1'b0;
    do_reset(2);
    n_issue = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pc_we_o === 1'b1) n_issue++;
      step();
    end
    checks++;
    if (n_issue != int'(DEPTH)) begin
      errors++;
      $display("FAIL issue_count got %0d want %0d", n_issue, DEPTH);
    end

    // Release from full for a single cycle.
    ready = 1'b1;
    step();
    ready = 1'b0;
    repeat (6) step();

    // Random ready, with occasional flushes and resets.
    for (int i = 0; i < 400; i++) begin
      ready       = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 19) == 0);
      rst_n       = ($urandom_range(0, 49) != 0);
      redirect    = flush;
      redirect_pc = $urandom & 32'h0000_fff8;
      step();
    end
    flush    = 1'b0;
    rst_n    = 1'b1;
    redirect = 1'b0;

    // Directed flush with three queued and one in flight.
    ready = 1'b0;
    do_reset(2);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 3 && inf_v) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL flush_setup got timeout want 3+1 occupancy");
    end
    flush       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1000;
    step();
    flush    = 1'b0;
    redirect = 1'b0;
    ready    = 1'b1;
    repeat (15) step();

    // Reset mid-stream with a full queue.
    ready = 1'b0;
    repeat (8) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (15) step();

    checks++;
    if (n_pops < 50) begin
      errors++;
      $display("FAIL pop_activity got %0d want >= 50", n_pops);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
